// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the 32-bit MIPS pipeline. It sits beside the decode stage
// and keeps a shadow copy of the destination register of each instruction in
// the DEPTH tracked stages after decode (stage 1 = EXE, 2 = MEM, 3 = WB).
// From that shadow it produces:
//   - a load-use stall,
//   - a forwarding select for each source operand,
//   - a multi-cycle flush after a taken branch.
// It also keeps saturating counts of stall cycles and taken branches.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   id_valid      decode holds a real instruction (0 = nop / bubble)
//   id_rs, id_rt  source register addresses A and B
//   id_rs_used    operand A is read
//   id_rt_used    operand B is read
//   id_dst        destination register address
//   id_wr         instruction writes the register file
//   id_load       instruction is a load (lw)
//   branch_taken  single-cycle pulse: branch resolved taken
//   stall         hold PC and IF/ID, insert a bubble into ID/EXE
//   flush         kill the IF/ID and ID/EXE contents
//   fwd_a, fwd_b  operand source: 0 = register file, k = stage k result
//   stall_count   saturating count of stall cycles
//   flush_count   saturating count of taken-branch pulses
//
// Parameters
//   DEPTH         number of tracked stages after decode
//   RAW           register address width
//   LOAD_READY    first stage whose result is usable for a load producer;
//                 non-load results are usable from stage 1
//   FLUSH_CYCLES  cycles flush stays high per taken branch (1 to 4)
//   CW            performance counter width
//   SW            forwarding select width; 2**SW must exceed DEPTH
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int DEPTH        = 3,
    parameter int RAW          = 5,
    parameter int LOAD_READY   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CW           = 16,
    parameter int SW           = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           id_rs_used,
    input  logic           id_rt_used,
    input  logic [RAW-1:0] id_dst,
    input  logic           id_wr,
    input  logic           id_load,
    input  logic           branch_taken,
    output logic           stall,
    output logic           flush,
    output logic [SW-1:0]  fwd_a,
    output logic [SW-1:0]  fwd_b,
    output logic [CW-1:0]  stall_count,
    output logic [CW-1:0]  flush_count
);

    // The flush down-counter only ever holds FLUSH_CYCLES-1, at most 3.
    localparam int               FCW          = 2;
    localparam logic [FCW-1:0]   FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);

    // Shadow of the tracked stages. Index k-1 holds stage k.
    logic [DEPTH-1:0] stg_valid;
    logic [DEPTH-1:0] stg_wr;
    logic [DEPTH-1:0] stg_load;
    logic [RAW-1:0]   stg_dst [DEPTH];

    logic [FCW-1:0]   flush_cnt;

    // Per-operand view: index 0 = operand A (rs), index 1 = operand B (rt).
    logic [RAW-1:0]   op_addr [2];
    logic [1:0]       op_used;
    logic [1:0]       near_hit;    // some stage produces this operand
    logic [1:0]       near_wait;   // nearest producer is a load not yet ready
    logic [SW-1:0]    near_k [2];  // stage number of the nearest producer

    logic             load_use;
    logic             id_accept;

    assign op_addr[0] = id_rs;
    assign op_addr[1] = id_rt;
    assign op_used[0] = id_rs_used;
    assign op_used[1] = id_rt_used;

    // -------------------------------------------------------------------------
    // Nearest producer search. Stages are scanned from the oldest to the
    // youngest so that the youngest match (smallest k) is the one that sticks.
    // Register 0 is hard-wired to zero and never forwards.
    // -------------------------------------------------------------------------
    always_comb begin
        near_hit  = '0;
        near_wait = '0;
        near_k[0] = '0;
        near_k[1] = '0;
        for (int o = 0; o < 2; o++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (stg_valid[k-1] && stg_wr[k-1] && op_used[o] &&
                    (op_addr[o] != '0) && (stg_dst[k-1] == op_addr[o])) begin
                    near_hit[o]  = 1'b1;
                    near_k[o]    = SW'(k);
                    near_wait[o] = stg_load[k-1] && (k < LOAD_READY);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control outputs. A bubble in decode never stalls or forwards. Flush
    // wins over stall: the decode instruction is being killed anyway, so
    // holding it would only lose a cycle.
    // -------------------------------------------------------------------------
    assign load_use  = id_valid && (near_wait[0] || near_wait[1]);
    assign flush     = branch_taken || (flush_cnt != '0);
    assign stall     = load_use && !flush;
    assign id_accept = id_valid && !stall && !flush;

    assign fwd_a = (id_accept && near_hit[0]) ? near_k[0] : '0;
    assign fwd_b = (id_accept && near_hit[1]) ? near_k[1] : '0;

    // -------------------------------------------------------------------------
    // Stage shift. Older entries always move on, even during a flush: the
    // branch resolves downstream of them, so they are architecturally live.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stg_valid <= '0;
            stg_wr    <= '0;
            stg_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stg_dst[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_wr[k]    <= stg_wr[k-1];
                stg_load[k]  <= stg_load[k-1];
                stg_dst[k]   <= stg_dst[k-1];
            end
            stg_valid[0] <= id_accept;
            stg_wr[0]    <= id_wr;
            stg_load[0]  <= id_load;
            stg_dst[0]   <= id_dst;
        end
    end

    // -------------------------------------------------------------------------
    // Flush window. The pulse cycle itself is covered by branch_taken, so the
    // counter only has to cover the remaining FLUSH_CYCLES-1 cycles. A new
    // pulse during an open window restarts it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_cnt <= '0;
        end else if (branch_taken) begin
            flush_cnt <= FLUSH_RELOAD;
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating event counters.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (branch_taken && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the 32-bit MIPS pipeline; sits beside the decode stage.
- Shadows the destination registers of up to DEPTH in-flight instructions downstream of decode.
- Generates a load-use stall, per-operand forwarding selects and a multi-cycle branch flush.
- Keeps saturating stall and flush event counters.
- Replaces the current hazard-free pipeline behaviour, where dependent instructions read stale register values.

Parameters:
DEPTH, 3, number of tracked stages after decode (1 = EXE, 2 = MEM, 3 = WB)
RAW, 5, register address width
LOAD_READY, 2, first tracked stage whose result is valid for a load producer; non-load results are valid from stage 1
FLUSH_CYCLES, 1, number of cycles flush stays asserted per taken branch (1 to 4)
CW, 16, performance counter width
SW, 2, forwarding select width; must satisfy 2^SW > DEPTH

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
id_valid  in  1  decode holds a real instruction (0 for nop or bubble)
id_rs  in  RAW  source register A
id_rt  in  RAW  source register B
id_rs_used  in  1  A is read
id_rt_used  in  1  B is read
id_dst  in  RAW  destination register
id_wr  in  1  instruction writes the register file
id_load  in  1  instruction is lw
branch_taken  in  1  single-cycle pulse: branch resolved taken
stall  out  1  hold PC and IF/ID; insert bubble into ID/EXE
flush  out  1  kill IF/ID and ID/EXE contents
fwd_a  out  SW  operand A source: 0 = register file, k = stage k result
fwd_b  out  SW  operand B source, same encoding
stall_count  out  CW  saturating count of stall cycles
flush_count  out  CW  saturating count of taken-branch events

Behaviour:
- Reset (reset low, asynchronous):
  - all stage entries invalid
  - flush counter cleared to 0
  - stall_count and flush_count cleared to 0
  - With entries invalid: stall = 0, flush = 0, fwd_a = 0, fwd_b = 0.
- Each stage entry holds {valid, dst, wr, load}.
- Every clock edge:
  - entries shift from stage k to stage k+1; the stage DEPTH entry is dropped
  - stage 1 loads the ID instruction only when id_valid = 1 and stall = 0 and flush = 0; otherwise stage 1 becomes invalid (bubble)
- Match rule for an operand: a stage k entry matches operand X when all of the following hold:
  - entry valid
  - entry wr = 1
  - entry dst = X
  - X != 0
  - the operand's *_used flag = 1
- Nearest producer: for each operand, the smallest k with a match is chosen.
  - fwd = k if the result is ready: entry load = 0, or k >= LOAD_READY.
  - fwd = 0 when no stage matches.
- Load-use stall:
  - stall = 1 (combinational) when the nearest producer for either operand is a load with k < LOAD_READY.
  - While stall = 1, both fwd outputs are 0.
  - Stall repeats each cycle until the load reaches LOAD_READY. With defaults this is exactly 1 stall cycle for a dependent instruction immediately after lw.
- Branch flush:
  - On branch_taken = 1, flush = 1 in that same cycle (combinational).
  - An internal down-counter is loaded with FLUSH_CYCLES-1; flush stays high while the counter is nonzero.
  - branch_taken during an active flush reloads the counter. flush_count increments on every branch_taken pulse.
- Simultaneous events:
  - Flush has priority over stall: when flush = 1, stall = 0 and fwd = 0.
  - The ID instruction is discarded, not entered into stage 1.
  - Older entries keep shifting and are not invalidated; the branch is resolved downstream of them.
- stall_count increments on each cycle with stall = 1.
- Both counters saturate at all-ones.
- id_valid = 0 forces stall = 0 and fwd = 0 regardless of register fields.
- Reset mid-flush or mid-stall deasserts both outputs immediately.

Test Plan:
1. Forward from EXE: add r3 = r1 + r2, then sub r4 = r3 - r5 → fwd_a = 1, fwd_b = 0, stall = 0.
2. Load-use: lw r6, then add r7 = r6 + r6 → stall = 1 for exactly 1 cycle; next cycle fwd_a = fwd_b = 2; stall_count = 1.
3. Nearest producer wins: add r3; or r3; and reading r3 → fwd_a = 1, not 2.
4. Register 0: add r0 = r1 + r2, then add r8 = r0 + r0 → fwd = 0, stall = 0.
5. Branch, FLUSH_CYCLES = 3: branch_taken pulse → flush = 1 for 3 cycles, stage 1 holds bubbles, flush_count = 1. A second pulse in cycle 2 extends flush to cycle 4 and sets flush_count = 2.
6. Simultaneous events and reset: load-use pending while branch_taken = 1 → flush = 1, stall = 0. Then assert reset low mid-flush → flush = 0 asynchronously, counters read 0.
